// File: rtl/sa_feeder_pkg.sv
// Shared types and sizing helpers for the systolic array feeder.
// Imported by the feeder top and its operand buffer.
package sa_feeder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        FEED,
        DRAIN,
        STREAM
    } state_e;

    function automatic int feed_cyc(
        input int m,
        input int n,
        input int k
    );
        return k + ((m > n) ? m : n) - 1;
    endfunction

    function automatic int drain_cyc(
        input int m,
        input int n
    );
        return m + n;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sa_operand_buf.sv
// Flat operand register buffer with indexed write and full read.
// Holds one operand tile; contents are rewritten every job.
module sa_operand_buf
    import sa_feeder_pkg::*;
#(
    parameter int DW    = 16,
    parameter int DEPTH = 16,
    localparam int IW   = cnt_w(DEPTH)
) (
    input  logic                      clk_i,
    input  logic                      we_i,
    input  logic [IW-1:0]             widx_i,
    input  logic [DW-1:0]             wdata_i,
    output logic [DEPTH-1:0][DW-1:0]  rdata_o
);

    // Write the addressed word; out-of-range indices are dropped.
    always_ff @(posedge clk_i) begin
        if (we_i && (int'(widx_i) < DEPTH)) begin
            rdata_o[widx_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// Loads A/B tiles, replays them skewed into the MAC array,
// then triggers stream-out and counts result words.
module systolic_feeder
    import sa_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int M_ROWS     = 4,
    parameter int N_COLS     = 4,
    parameter int K_DEPTH    = 4,
    localparam int TOTAL_ELEM = M_ROWS * N_COLS
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                start_i,
    input  logic                                ld_valid_i,
    output logic                                ld_ready_o,
    input  logic [DATA_WIDTH-1:0]               ld_data_i,
    output logic [M_ROWS-1:0][DATA_WIDTH-1:0]   array_a_o,
    output logic [N_COLS-1:0][DATA_WIDTH-1:0]   array_b_o,
    output logic                                feed_a_valid_o,
    output logic                                feed_b_valid_o,
    output logic                                a_clr_o,
    output logic                                b_clr_o,
    output logic                                acc_clr_o,
    output logic                                stream_clr_o,
    output logic                                start_stream_o,
    input  logic                                stream_valid_i,
    output logic                                busy_o,
    output logic                                done_o
);

    localparam int A_WORDS = M_ROWS * K_DEPTH;
    localparam int B_WORDS = K_DEPTH * N_COLS;
    localparam int LD_TOT  = A_WORDS + B_WORDS;
    localparam int FEED_C  = feed_cyc(M_ROWS, N_COLS, K_DEPTH);
    localparam int DRAIN_C = drain_cyc(M_ROWS, N_COLS);
    localparam int LD_W    = cnt_w(LD_TOT);
    localparam int FD_W    = cnt_w(FEED_C);
    localparam int DR_W    = cnt_w(DRAIN_C);
    localparam int ST_W    = cnt_w(TOTAL_ELEM + 1);
    localparam int AI_W    = cnt_w(A_WORDS);
    localparam int BI_W    = cnt_w(B_WORDS);

    state_e                  state;
    logic [LD_W-1:0]         ld_cnt;
    logic [FD_W-1:0]         fd_cnt;
    logic [DR_W-1:0]         dr_cnt;
    logic [ST_W-1:0]         st_cnt;
    logic                    clr_q;
    logic                    feed_q;

    logic                    ld_fire;
    logic                    in_a;
    logic                    a_we;
    logic                    b_we;
    logic [AI_W-1:0]         a_idx;
    logic [BI_W-1:0]         b_idx;

    logic [A_WORDS-1:0][DATA_WIDTH-1:0] a_mem;
    logic [B_WORDS-1:0][DATA_WIDTH-1:0] b_mem;

    assign ld_fire = ld_valid_i && ld_ready_o;
    assign in_a    = ld_cnt < LD_W'(A_WORDS);
    assign a_we    = ld_fire && in_a;
    assign b_we    = ld_fire && !in_a;
    assign a_idx   = AI_W'(ld_cnt);
    assign b_idx   = BI_W'(ld_cnt - LD_W'(A_WORDS));

    sa_operand_buf #(
        .DW    (DATA_WIDTH),
        .DEPTH (A_WORDS)
    ) u_a_buf (
        .clk_i   (clk_i),
        .we_i    (a_we),
        .widx_i  (a_idx),
        .wdata_i (ld_data_i),
        .rdata_o (a_mem)
    );

    sa_operand_buf #(
        .DW    (DATA_WIDTH),
        .DEPTH (B_WORDS)
    ) u_b_buf (
        .clk_i   (clk_i),
        .we_i    (b_we),
        .widx_i  (b_idx),
        .wdata_i (ld_data_i),
        .rdata_o (b_mem)
    );

    assign a_clr_o        = clr_q;
    assign b_clr_o        = clr_q;
    assign acc_clr_o      = clr_q;
    assign stream_clr_o   = clr_q;
    assign feed_a_valid_o = feed_q;
    assign feed_b_valid_o = feed_q;
    assign busy_o         = (state != IDLE);

    // Job sequencer: phase counters and registered control pulses.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state          <= IDLE;
            ld_cnt         <= '0;
            fd_cnt         <= '0;
            dr_cnt         <= '0;
            st_cnt         <= '0;
            clr_q          <= 1'b0;
            feed_q         <= 1'b0;
            ld_ready_o     <= 1'b0;
            start_stream_o <= 1'b0;
            done_o         <= 1'b0;
        end else begin
            clr_q          <= 1'b0;
            start_stream_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        state <= CLEAR;
                        clr_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    ld_cnt     <= '0;
                    ld_ready_o <= 1'b1;
                    state      <= LOAD;
                end
                LOAD: begin
                    if (ld_fire) begin
                        if (ld_cnt == LD_W'(LD_TOT - 1)) begin
                            ld_ready_o <= 1'b0;
                            feed_q     <= 1'b1;
                            fd_cnt     <= '0;
                            state      <= FEED;
                        end else begin
                            ld_cnt <= ld_cnt + 1'b1;
                        end
                    end
                end
                FEED: begin
                    if (fd_cnt == FD_W'(FEED_C - 1)) begin
                        feed_q <= 1'b0;
                        dr_cnt <= '0;
                        state  <= DRAIN;
                    end else begin
                        fd_cnt <= fd_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (dr_cnt == DR_W'(DRAIN_C - 1)) begin
                        start_stream_o <= 1'b1;
                        st_cnt         <= '0;
                        state          <= STREAM;
                    end else begin
                        dr_cnt <= dr_cnt + 1'b1;
                    end
                end
                STREAM: begin
                    // done_o is held for one STREAM cycle, then IDLE.
                    if (done_o) begin
                        done_o <= 1'b0;
                        state  <= IDLE;
                    end else if (stream_valid_i) begin
                        st_cnt <= st_cnt + 1'b1;
                        if (st_cnt == ST_W'(TOTAL_ELEM - 1)) begin
                            done_o <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Diagonal skew: row m sees A[m][t-m], column n sees B[t-n][n].
    always_comb begin
        array_a_o = '0;
        array_b_o = '0;
        if (state == FEED) begin
            for (int m = 0; m < M_ROWS; m++) begin
                for (int k = 0; k < K_DEPTH; k++) begin
                    if (int'(fd_cnt) == m + k) begin
                        array_a_o[m] = a_mem[m*K_DEPTH + k];
                    end
                end
            end
            for (int n = 0; n < N_COLS; n++) begin
                for (int k = 0; k < K_DEPTH; k++) begin
                    if (int'(fd_cnt) == n + k) begin
                        array_b_o[n] = b_mem[k*N_COLS + n];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder with default sizing.
// Directed jobs, skew vector table and multi-cycle corner sequences.
module tb_systolic_feeder;

    localparam int DW = 16;
    localparam int M  = 4;
    localparam int N  = 4;
    localparam int K  = 4;
    localparam int FC = 7;
    localparam int DC = 8;
    localparam int TE = 16;
    localparam int MK = M * K;
    localparam int LT = M * K + K * N;

    logic                  clk = 1'b0;
    logic                  rst_ni;
    logic                  start_i;
    logic                  ld_valid_i;
    logic                  ld_ready_o;
    logic [DW-1:0]         ld_data_i;
    logic [M-1:0][DW-1:0]  array_a_o;
    logic [N-1:0][DW-1:0]  array_b_o;
    logic                  feed_a_valid_o;
    logic                  feed_b_valid_o;
    logic                  a_clr_o;
    logic                  b_clr_o;
    logic                  acc_clr_o;
    logic                  stream_clr_o;
    logic                  start_stream_o;
    logic                  stream_valid_i;
    logic                  busy_o;
    logic                  done_o;

    always #5 clk = ~clk;

    systolic_feeder #(
        .DATA_WIDTH (DW),
        .M_ROWS     (M),
        .N_COLS     (N),
        .K_DEPTH    (K)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .ld_valid_i     (ld_valid_i),
        .ld_ready_o     (ld_ready_o),
        .ld_data_i      (ld_data_i),
        .array_a_o      (array_a_o),
        .array_b_o      (array_b_o),
        .feed_a_valid_o (feed_a_valid_o),
        .feed_b_valid_o (feed_b_valid_o),
        .a_clr_o        (a_clr_o),
        .b_clr_o        (b_clr_o),
        .acc_clr_o      (acc_clr_o),
        .stream_clr_o   (stream_clr_o),
        .start_stream_o (start_stream_o),
        .stream_valid_i (stream_valid_i),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    typedef struct {
        int            t;
        int            lane;
        bit            is_b;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t          vecs[14];
    logic [DW-1:0] a_mat[M][K];
    logic [DW-1:0] b_mat[K][N];
    logic [DW-1:0] fa[FC][M];
    logic [DW-1:0] fb[FC][N];
    logic [DW-1:0] gold_fa[FC][M];
    logic [DW-1:0] gold_fb[FC][N];

    int tests    = 0;
    int fails    = 0;
    int jobs     = 0;
    int clr_seen = 0;

    always @(negedge clk) begin
        if (rst_ni && a_clr_o) clr_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic any_out();
        return ld_ready_o | (|array_a_o) | (|array_b_o) |
               feed_a_valid_o | feed_b_valid_o | a_clr_o | b_clr_o |
               acc_clr_o | stream_clr_o | start_stream_o | busy_o | done_o;
    endfunction

    function automatic logic [DW-1:0] beat_word(input int b);
        if (b < MK) return a_mat[b/K][b%K];
        return b_mat[(b-MK)/N][(b-MK)%N];
    endfunction

    task automatic set_pattern();
        for (int m = 0; m < M; m++)
            for (int k = 0; k < K; k++)
                a_mat[m][k] = DW'(16*m + k);
        for (int k = 0; k < K; k++)
            for (int n = 0; n < N; n++)
                b_mat[k][n] = DW'(16*k + n);
    endtask

    task automatic set_const(input logic [DW-1:0] av,
                             input logic [DW-1:0] bv);
        for (int m = 0; m < M; m++)
            for (int k = 0; k < K; k++)
                a_mat[m][k] = av;
        for (int k = 0; k < K; k++)
            for (int n = 0; n < N; n++)
                b_mat[k][n] = bv;
    endtask

    // One full job; abort_t >= 0 resets the DUT at that feed step.
    task automatic run_job(input string tag, input bit gaps,
                           input bit noise, input int abort_t,
                           input int exp_c);
        int beat, cyc, nf, nd, sent, dones, at_done, bad, pad, cbad;
        int ref_c, got_c;
        jobs++;
        bad = 0;
        stream_valid_i = 1'b0;
        ld_valid_i = noise;
        ld_data_i = 16'hffff;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check({tag, "_clear"},
              {a_clr_o, b_clr_o, acc_clr_o, stream_clr_o,
               ld_ready_o, busy_o}, 6'b111101);
        tick();
        check({tag, "_ld_ready"}, {ld_ready_o, a_clr_o}, 2'b10);
        beat = 0;
        cyc = 0;
        while (beat < LT && cyc < 200) begin
            ld_valid_i = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            ld_data_i = beat_word(beat);
            start_i = noise && (cyc == 5);
            if (!busy_o || feed_a_valid_o) bad++;
            if (ld_valid_i && ld_ready_o) beat++;
            tick();
            cyc++;
        end
        start_i = 1'b0;
        ld_valid_i = noise;
        ld_data_i = 16'hffff;
        check({tag, "_beats"}, beat, LT);
        if (!gaps) check({tag, "_load_cycles"}, cyc, LT);
        check({tag, "_feed_entry"}, {feed_a_valid_o, ld_ready_o}, 2'b10);
        nf = 0;
        while (feed_a_valid_o && nf < 20) begin
            if (nf < FC) begin
                for (int m = 0; m < M; m++) fa[nf][m] = array_a_o[m];
                for (int n = 0; n < N; n++) fb[nf][n] = array_b_o[n];
            end
            if (!feed_b_valid_o || ld_ready_o || !busy_o) bad++;
            start_i = noise && (nf == 2);
            stream_valid_i = noise;
            if (nf == abort_t) begin
                rst_ni = 1'b0;
                tick();
                rst_ni = 1'b1;
                start_i = 1'b0;
                stream_valid_i = 1'b0;
                ld_valid_i = 1'b0;
                check({tag, "_reset_outs"}, any_out(), 1'b0);
                return;
            end
            tick();
            nf++;
        end
        start_i = 1'b0;
        check({tag, "_feed_cycles"}, nf, FC);
        nd = 0;
        while (!start_stream_o && nd < 20) begin
            if (feed_a_valid_o || feed_b_valid_o || (|array_a_o) ||
                (|array_b_o) || ld_ready_o || !busy_o) bad++;
            tick();
            nd++;
        end
        ld_valid_i = 1'b0;
        check({tag, "_drain_cycles"}, nd, DC);
        sent = 0;
        dones = 0;
        at_done = -1;
        cyc = 0;
        while (busy_o && cyc < 100) begin
            if (cyc > 0 && start_stream_o) bad++;
            if (ld_ready_o || feed_a_valid_o) bad++;
            if (done_o) begin
                dones++;
                at_done = sent;
            end
            start_i = noise && (cyc == 0 || done_o);
            stream_valid_i = (sent < TE) &&
                             (gaps ? 1'($urandom_range(0, 1)) : 1'b1);
            if (stream_valid_i) sent++;
            tick();
            cyc++;
        end
        start_i = 1'b0;
        stream_valid_i = 1'b0;
        check({tag, "_idle_after"}, {busy_o, done_o}, 2'b00);
        check({tag, "_done_pulses"}, dones, 1);
        check({tag, "_done_after"}, at_done, TE);
        check({tag, "_phase_errs"}, bad, 0);
        check({tag, "_clear_count"}, clr_seen, jobs);
        pad = 0;
        for (int t = 0; t < FC; t++) begin
            for (int m = 0; m < M; m++)
                if ((t - m < 0 || t - m >= K) && fa[t][m] != 0) pad++;
            for (int n = 0; n < N; n++)
                if ((t - n < 0 || t - n >= K) && fb[t][n] != 0) pad++;
        end
        check({tag, "_padding"}, pad, 0);
        cbad = 0;
        for (int m = 0; m < M; m++) begin
            for (int n = 0; n < N; n++) begin
                ref_c = 0;
                got_c = 0;
                for (int k = 0; k < K; k++) begin
                    ref_c += int'(a_mat[m][k]) * int'(b_mat[k][n]);
                    got_c += int'(fa[m+k][m]) * int'(fb[n+k][n]);
                end
                if (got_c != ref_c) cbad++;
                if (exp_c >= 0 && got_c != exp_c) cbad++;
            end
        end
        check({tag, "_results"}, cbad, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int diffs;
        vecs[0]  = '{0, 0, 1'b0, 16'h0000};
        vecs[1]  = '{0, 1, 1'b0, 16'h0000};
        vecs[2]  = '{0, 3, 1'b0, 16'h0000};
        vecs[3]  = '{0, 0, 1'b1, 16'h0000};
        vecs[4]  = '{1, 1, 1'b0, 16'h0010};
        vecs[5]  = '{1, 1, 1'b1, 16'h0001};
        vecs[6]  = '{3, 3, 1'b0, 16'h0030};
        vecs[7]  = '{3, 0, 1'b0, 16'h0003};
        vecs[8]  = '{3, 1, 1'b0, 16'h0012};
        vecs[9]  = '{3, 2, 1'b1, 16'h0012};
        vecs[10] = '{3, 0, 1'b1, 16'h0030};
        vecs[11] = '{6, 3, 1'b0, 16'h0033};
        vecs[12] = '{6, 2, 1'b0, 16'h0000};
        vecs[13] = '{6, 3, 1'b1, 16'h0033};

        rst_ni = 1'b0;
        start_i = 1'b0;
        ld_valid_i = 1'b0;
        ld_data_i = '0;
        stream_valid_i = 1'b0;
        tick();
        tick();
        check("reset_outs", any_out(), 1'b0);
        rst_ni = 1'b1;
        ld_valid_i = 1'b1;
        stream_valid_i = 1'b1;
        repeat (3) tick();
        check("idle_ignores_inputs", any_out(), 1'b0);
        ld_valid_i = 1'b0;
        stream_valid_i = 1'b0;

        set_pattern();
        run_job("pattern", 1'b0, 1'b0, -1, -1);
        for (int i = 0; i < 14; i++) begin
            logic [DW-1:0] got;
            got = vecs[i].is_b ? fb[vecs[i].t][vecs[i].lane]
                               : fa[vecs[i].t][vecs[i].lane];
            check($sformatf("skew_vec%0d_t%0d_%s%0d", i, vecs[i].t,
                            vecs[i].is_b ? "b" : "a", vecs[i].lane),
                  got, vecs[i].exp);
        end
        gold_fa = fa;
        gold_fb = fb;

        run_job("pattern_gaps", 1'b1, 1'b0, -1, -1);
        diffs = 0;
        for (int t = 0; t < FC; t++) begin
            for (int m = 0; m < M; m++) if (fa[t][m] !== gold_fa[t][m]) diffs++;
            for (int n = 0; n < N; n++) if (fb[t][n] !== gold_fb[t][n]) diffs++;
        end
        check("gaps_same_feed", diffs, 0);

        set_const(16'd1, 16'd2);
        run_job("ones_twos", 1'b0, 1'b0, -1, 8);
        run_job("busy_noise", 1'b0, 1'b1, -1, 8);
        run_job("abort", 1'b0, 1'b0, 4, -1);
        run_job("after_reset", 1'b0, 1'b0, -1, 8);
        set_const(16'd1, 16'd3);
        run_job("back_to_back", 1'b0, 1'b0, -1, 12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
